// File: rtl/regfile_pkg.sv
// Shared types and default constants for the multi-port register file.
package regfile_pkg;

  localparam int          XLEN_DEF    = 32;
  localparam int          NREGS_DEF   = 32;
  localparam int          SP_IDX_DEF  = 2;
  localparam logic [31:0] SP_INIT_DEF = 32'h8000;

  typedef enum logic {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } rf_state_e;

endpackage

// File: rtl/regfile_clear_seq.sv
// Post-reset clear sequencer: walks clr_idx over 1..NREGS-1, then raises ready.
module regfile_clear_seq
  import regfile_pkg::*;
#(
  parameter int NREGS = NREGS_DEF,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          clr_we,
  output logic [AW-1:0] clr_idx,
  output logic          ready
);

  rf_state_e state, state_nxt;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
    end else begin
      state <= state_nxt;
      if (state == CLEAR) clr_idx <= clr_idx + AW'(1);
    end
  end

  // NOTE: every output of this always_comb gets a default first, so no path
  // through the case leaves a value held and no latch is inferred.
  always_comb begin
    state_nxt = state;
    clr_we    = 1'b0;
    ready     = 1'b0;
    case (state)
      CLEAR: begin
        clr_we = 1'b1;
        if (clr_idx == AW'(NREGS - 1)) state_nxt = RUN;
      end
      RUN:     ready = 1'b1;
      default: state_nxt = CLEAR;
    endcase
  end

endmodule

// File: rtl/regfile_mp.sv
// Multi-read, dual-write register file with x0 hardwired to zero and write bypass.
// Optional issue scoreboard (rd_busy) enabled by defining REGFILE_SCOREBOARD_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int               XLEN    = XLEN_DEF,
  parameter int               NREGS   = NREGS_DEF,
  parameter int               NRD     = 2,
  parameter int               SP_IDX  = SP_IDX_DEF,
  parameter logic [XLEN-1:0]  SP_INIT = XLEN'(SP_INIT_DEF),
  localparam int              AW      = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                ready,
  input  logic [NRD*AW-1:0]   raddr,
  output logic [NRD*XLEN-1:0] rdata,
  input  logic [1:0]          we,
  input  logic [2*AW-1:0]     waddr,
  input  logic [2*XLEN-1:0]   wdata
`ifdef REGFILE_SCOREBOARD_EN
  ,
  input  logic                iss_valid,
  input  logic [AW-1:0]       iss_addr,
  output logic [NRD-1:0]      rd_busy
`endif
);

  logic            clr_we;
  logic [AW-1:0]   clr_idx;
  logic [AW-1:0]   wa [2];
  logic [XLEN-1:0] wd [2];
  logic [1:0]      wr_en;

  // NOTE: the array has no reset; the clear sequence initialises it, which
  // keeps it mappable onto plain RAM/flop arrays without reset fan-out.
  logic [XLEN-1:0] regs [NREGS];

  regfile_clear_seq #(.NREGS(NREGS)) u_clear_seq (
    .clk     (clk),
    .rst     (rst),
    .clr_we  (clr_we),
    .clr_idx (clr_idx),
    .ready   (ready)
  );

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      wa[p]    = waddr[p*AW +: AW];
      wd[p]    = wdata[p*XLEN +: XLEN];
      wr_en[p] = ready && we[p] && (wa[p] != '0);
    end
  end

  // Port 1 is applied after port 0, so it wins on an address collision.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      regs[clr_idx] <= (clr_idx == AW'(SP_IDX)) ? SP_INIT : '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p]) regs[wa[p]] <= wd[p];
    end
  end

`ifdef REGFILE_SCOREBOARD_EN
  logic [NREGS-1:0] pending;

  // Set is applied last so an issue beats a same-cycle write to that register.
  always_ff @(posedge clk) begin
    if (rst || !ready) begin
      pending <= '0;
    end else begin
      for (int p = 0; p < 2; p++)
        if (wr_en[p]) pending[wa[p]] <= 1'b0;
      if (iss_valid && iss_addr != '0) pending[iss_addr] <= 1'b1;
    end
  end
`endif

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] val;
    logic            wr_hit;

    assign ra     = raddr[i*AW +: AW];
    assign wr_hit = (wr_en[0] && wa[0] == ra) || (wr_en[1] && wa[1] == ra);

    always_comb begin
      val = '0;
      if (ready && ra != '0) begin
        val = regs[ra];
        for (int p = 0; p < 2; p++)
          if (wr_en[p] && wa[p] == ra) val = wd[p];
      end
    end

    assign rdata[i*XLEN +: XLEN] = val;

`ifdef REGFILE_SCOREBOARD_EN
    assign rd_busy[i] = ready && (ra != '0) && pending[ra] && !wr_hit;
`else
    logic unused_hit;
    assign unused_hit = wr_hit;
`endif
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Directed self-checking bench for regfile_mp (default parameters).
module tb_regfile_mp;
  import regfile_pkg::*;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;

  logic                clk = 1'b0;
  logic                rst;
  logic                ready;
  logic [NRD*AW-1:0]   raddr;
  logic [NRD*XLEN-1:0] rdata;
  logic [1:0]          we;
  logic [2*AW-1:0]     waddr;
  logic [2*XLEN-1:0]   wdata;
`ifdef REGFILE_SCOREBOARD_EN
  logic                iss_valid;
  logic [AW-1:0]       iss_addr;
  logic [NRD-1:0]      rd_busy;
`endif

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  regfile_mp dut (
    .clk   (clk),
    .rst   (rst),
    .ready (ready),
    .raddr (raddr),
    .rdata (rdata),
    .we    (we),
    .waddr (waddr),
    .wdata (wdata)
`ifdef REGFILE_SCOREBOARD_EN
    ,
    .iss_valid (iss_valid),
    .iss_addr  (iss_addr),
    .rd_busy   (rd_busy)
`endif
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  function automatic logic [XLEN-1:0] rd(input int lane);
    return rdata[lane*XLEN +: XLEN];
  endfunction

  task automatic set_rd(input int lane, input int addr);
    raddr[lane*AW +: AW] = AW'(addr);
  endtask

  task automatic set_wr(input int port, input int addr, input logic [XLEN-1:0] data);
    waddr[port*AW +: AW]     = AW'(addr);
    wdata[port*XLEN +: XLEN] = data;
  endtask

  // One-cycle rst pulse; returns just after the falling edge where rst drops.
  task automatic pulse_rst();
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
  endtask

  // Counts rising edges after rst deasserts until ready is seen high.
  // With poke set, a write to x3 is held during the middle of the clear.
  task automatic wait_ready(input bit poke);
    int cnt = 0;
    while (!ready && cnt < 100) begin
      @(posedge clk);
      #1;
      cnt++;
      if (poke && cnt == 5) begin
        we = 2'b01;
        set_wr(0, 3, 32'h55);
        set_rd(0, 3);
      end
      if (poke && cnt == 10) begin
        check("clear_rdata_zero", rd(0), 0);
        check("clear_ready_low", ready, 0);
      end
      if (poke && cnt == 20) we = 2'b00;
    end
    check("ready_latency", cnt, 31);
    we = 2'b00;
  endtask

  task automatic check_all_regs(input string pfx);
    for (int i = 0; i < NREGS; i++) begin
      set_rd(i % 2, i);
      #1;
      check($sformatf("%s_x%0d", pfx, i), rd(i % 2), (i == 2) ? 32'h8000 : 32'h0);
    end
  endtask

  initial begin
    rst   = 1'b1;
    we    = 2'b00;
    raddr = '0;
    waddr = '0;
    wdata = '0;
`ifdef REGFILE_SCOREBOARD_EN
    iss_valid = 1'b0;
    iss_addr  = '0;
`endif

    // Reset and full clear
    pulse_rst();
    #1;
    check("ready_after_rst", ready, 0);
    wait_ready(1'b0);
    check_all_regs("init");

    // Single write with same-cycle bypass
    @(negedge clk);
    we = 2'b01;
    set_wr(0, 5, 32'hDEADBEEF);
    set_rd(0, 5);
    #1 check("bypass_x5", rd(0), 32'hDEADBEEF);
    @(negedge clk) we = 2'b00;
    #1 check("x5_next", rd(0), 32'hDEADBEEF);
    @(negedge clk);
    #1 check("x5_later", rd(0), 32'hDEADBEEF);

    // Dual-write collision: port 1 wins
    @(negedge clk);
    we = 2'b11;
    set_wr(0, 7, 32'd1);
    set_wr(1, 7, 32'd2);
    set_rd(1, 7);
    #1 check("collide_bypass", rd(1), 32'd2);
    @(negedge clk) we = 2'b00;
    #1 check("collide_x7", rd(1), 32'd2);

    // Two writes to different addresses
    @(negedge clk);
    we = 2'b11;
    set_wr(0, 10, 32'hA0A0A0A0);
    set_wr(1, 11, 32'h0B0B0B0B);
    @(negedge clk) we = 2'b00;
    set_rd(0, 10);
    set_rd(1, 11);
    #1;
    check("dual_x10", rd(0), 32'hA0A0A0A0);
    check("dual_x11", rd(1), 32'h0B0B0B0B);

    // x0 writes are discarded and never bypass
    @(negedge clk);
    we = 2'b11;
    set_wr(0, 0, 32'hFFFFFFFF);
    set_wr(1, 0, 32'hFFFFFFFF);
    set_rd(0, 0);
    set_rd(1, 2);
    #1;
    check("x0_during", rd(0), 0);
    check("sp_untouched", rd(1), 32'h8000);
    @(negedge clk) we = 2'b00;
    #1 check("x0_after", rd(0), 0);

    // Reset mid-clear (clr_idx==10), writes issued during the restarted clear
    pulse_rst();
    repeat (9) @(posedge clk);
    @(negedge clk) rst = 1'b1;
    @(posedge clk);
    @(negedge clk) rst = 1'b0;
    wait_ready(1'b1);
    check_all_regs("reclr");

`ifdef REGFILE_SCOREBOARD_EN
    // Issue sets pending, write clears it, issue wins a same-cycle clash
    @(negedge clk);
    set_rd(0, 9);
    set_rd(1, 0);
    iss_valid = 1'b1;
    iss_addr  = 5'd9;
    #1 check("busy_issue_cycle", rd_busy[0], 0);
    @(negedge clk) iss_valid = 1'b0;
    #1;
    check("busy_after_issue", rd_busy[0], 1);
    check("busy_x0", rd_busy[1], 0);
    @(negedge clk);
    we = 2'b01;
    set_wr(0, 9, 32'h99);
    #1 check("busy_write_cycle", rd_busy[0], 0);
    @(negedge clk) we = 2'b00;
    #1 check("busy_cleared", rd_busy[0], 0);
    @(negedge clk);
    iss_valid = 1'b1;
    we = 2'b01;
    @(negedge clk);
    iss_valid = 1'b0;
    we = 2'b00;
    #1 check("busy_set_wins", rd_busy[0], 1);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter XLEN, default 32, data width in bits.
REQ-002 SHALL have parameter NREGS, default 32, register count (power of two, >=4); AW = clog2(NREGS).
REQ-003 SHALL have parameter NRD, default 2, read-port count (1..4).
REQ-004 SHALL have parameter SP_IDX, default 2, index of the stack-pointer register.
REQ-005 SHALL have parameter SP_INIT, default 32'h8000, stack-pointer value loaded after clear.
REQ-006 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-007 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-008 SHALL have port ready, output, 1, high when the register array is initialised and accepting writes.
REQ-009 SHALL have port raddr, input, NRD*AW, packed read addresses; port i at bits [i*AW +: AW].
REQ-010 SHALL have port rdata, output, NRD*XLEN, packed read data; port i at bits [i*XLEN +: XLEN].
REQ-011 SHALL have port we, input, 2, write enables for write ports 0 and 1.
REQ-012 SHALL have port waddr, input, 2*AW, packed write addresses.
REQ-013 SHALL have port wdata, input, 2*XLEN, packed write data.

Function
REQ-014 SHALL implement a two-state FSM: CLEAR (ready=0) and RUN (ready=1).
REQ-015 In CLEAR, a counter clr_idx SHALL step from 1 to NREGS-1 at one index per cycle, writing 0 to each register, and SP_INIT when clr_idx==SP_IDX.
REQ-016 The FSM SHALL move CLEAR->RUN on the cycle after clr_idx==NREGS-1 is written; ready SHALL first be high NREGS-1 cycles after rst deasserts.
REQ-017 In CLEAR, we SHALL be ignored and every rdata lane SHALL read 0.
REQ-018 In RUN, reads SHALL be combinational: address 0 reads 0; otherwise data is bypassed from a same-cycle write to that address, else taken from the array.
REQ-019 A write to address 0 SHALL be discarded and SHALL NOT bypass.
REQ-020 When both write ports target the same nonzero address, port 1 SHALL win for both the array update and the bypass.
REQ-021 Writes to different addresses in the same cycle SHALL both commit at the rising edge.

Reset
REQ-022 rst high at a clock edge SHALL force CLEAR, set clr_idx=1, and set ready=0 on the next cycle; this applies from any state, including mid-clear.
REQ-023 Array contents SHALL change only through the clear sequence or writes, never asynchronously.

Configuration
REQ-024 Macro REGFILE_SCOREBOARD_EN SHALL add inputs iss_valid (1) and iss_addr (AW), output rd_busy (NRD), and a pending bit per register.
REQ-025 With the macro defined: iss_valid with nonzero iss_addr in RUN SHALL set pending[iss_addr]; any write commit SHALL clear pending[waddr]; if set and clear hit the same address in one cycle, set SHALL win.
REQ-026 With the macro defined: rd_busy[i] SHALL equal pending[raddr_i] AND NOT (a same-cycle write to raddr_i); it SHALL be 0 for address 0; rst and CLEAR SHALL zero all pending bits.
REQ-027 Without the macro, none of these ports or any pending state SHALL exist.

Structure
REQ-028 Package regfile_pkg SHALL hold the FSM state enum (CLEAR, RUN) and the default constants for XLEN, NREGS, SP_IDX and SP_INIT.
REQ-029 The clear counter and FSM SHALL be implemented in sub-module regfile_clear_seq, which outputs clr_we, clr_idx and ready.

Verification
REQ-030 Reset test: pulse rst for 1 cycle, with NREGS=32 -> ready rises exactly 31 cycles after rst deasserts; register x2 reads 32'h8000; all others read 0.
REQ-031 Write/bypass test: in RUN, we=01, waddr0=5, wdata0=32'hDEADBEEF, raddr lane0=5 -> rdata lane0 = DEADBEEF in the same cycle and every later cycle.
REQ-032 Dual-write collision test: we=11, both waddr=7, wdata0=1, wdata1=2 -> bypass reads 2; x7 reads 2 on the next cycle.
REQ-033 x0 test: write 32'hFFFFFFFF to address 0 -> reads of address 0 return 0, both during the write cycle and after it.
REQ-034 Reset-mid-clear test: assert rst while clr_idx=10 -> the counter restarts at 1 and ready rises 31 cycles after rst deasserts; writes issued during CLEAR have no effect.
REQ-035 Scoreboard test (REGFILE_SCOREBOARD_EN defined): issue x9 -> rd_busy=1 on the following cycle; write x9 -> rd_busy=0 in the write cycle; issuing and writing x9 in the same cycle leaves pending[9]=1.
